arith_scheduler: RTL
====================

# arith_scheduler

Two-requester scheduler that shares the single arithmetic unit (add/sub/mul) between two independent operation sources. Accepts one request at a time over a valid/ready handshake, drives the unit's enable, function and operand inputs, captures the registered result after a fixed latency, and returns it on the winning requester's response channel. Sits between the requesters and the arithmetic unit inside the ALU top level.

## Interface
- A_width, 16, operand A width
- B_width, 16, operand B width
- OUT_width, A_width+B_width, result width
- ARITH_LAT, 1, cycles from the enable edge to a valid unit output (≥1)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- REQ0_VALID / REQ1_VALID  in  1  request present
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle when VALID&READY
- REQ0_FUN / REQ1_FUN  in  2  00 add, 01 sub, 10 mul, 11 div (unsupported)
- REQ0_A / REQ1_A  in  A_width  operand A
- REQ0_B / REQ1_B  in  B_width  operand B
- RSP0_VALID / RSP1_VALID  out  1  response present, held until READY
- RSP0_READY / RSP1_READY  in  1  response consumed
- RSP_RESULT  out  OUT_width  result, shared by both response channels
- RSP_CARRY  out  1  bit A_width of the captured result
- RSP_ERR  out  1  1 = unsupported function, result forced to 0
- ARITH_EN  out  1  to unit enable
- ALU_FUN_ARITH  out  2  to unit function select
- A_IN_ARITH / B_IN_ARITH  out  A_width / B_width  to unit operands
- ARITH_OUT  in  OUT_width  from unit

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: REQx_READY = REQx_VALID gated by arbitration; at most one READY high. If only one VALID, grant it. If both, grant the requester opposite to LAST_GRANT. On accept, latch the operands, function and grant id, and update LAST_GRANT.
- Accepted FUN = 11: go directly to RESP with RESULT = 0, CARRY = 0, ERR = 1. ARITH_EN is never asserted.
- Accepted FUN = 00/01/10: go to ISSUE.
- ISSUE (one cycle): ARITH_EN = 1, with ALU_FUN_ARITH, A_IN_ARITH and B_IN_ARITH driven from the latched values. Load the latency counter with ARITH_LAT-1 and go to WAIT.
- WAIT: ARITH_EN = 0. Operand and function outputs hold their latched values. Decrement the counter.
  - When the counter is 0, capture ARITH_OUT into RSP_RESULT and ARITH_OUT[A_width] into RSP_CARRY, clear ERR, and go to RESP.
  - ARITH_OUT is valid for only one cycle after the enable, because the unit zeroes it when EN is low. The capture must land on that exact cycle.
- RESP: RSPg_VALID = 1 for the granted id only. RESULT, CARRY and ERR are stable. On RSPg_READY, go to IDLE.
- No REQx_READY outside IDLE. No new accept in the same cycle as a response handshake.
- The unit's ARITH_FLAG is not used: it is sticky after the first enable and carries no per-operation meaning.
- Width rules:
  - Sub result is the OUT_width two's-complement wrap of A-B.
  - Mul result is the full OUT_width product.
  - Operands are zero-extended.

## Timing
- Reset values: all READY/VALID = 0, ARITH_EN = 0, ALU_FUN_ARITH = 0, A/B outputs = 0, RSP_RESULT = 0, RSP_CARRY = 0, RSP_ERR = 0, LAST_GRANT = 1 (REQ0 wins the first tie), state IDLE, counter = 0.
- Accept at cycle T. ISSUE is T+1. Capture at the end of T+1+ARITH_LAT. RSP_VALID from T+2+ARITH_LAT.
- With ARITH_LAT = 1: response at T+3. Minimum issue interval is 4 cycles when RSP_READY is tied high.
- Unsupported op: RSP_VALID at T+1.
- Reset mid-operation: immediate return to IDLE with reset values. The in-flight op is dropped and no response is produced.
- A requester dropping VALID after the handshake has no effect. Operands are already latched.
- RSP_READY asserted outside RESP is ignored.

## Structure
- A shared package holds:
  - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
  - function codes ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11
  - grant id constants
- One natural sub-module: `rr_arbiter2`, a two-way round-robin grant with an update strobe and a LAST_GRANT register. The FSM, latency counter and result registers stay in the top module.

## Test plan
- Single add: REQ0 A=0xFFFF, B=0x0001, FUN=00. RSP0_VALID at T+3 with RESULT=0x00010000, CARRY=1, ERR=0. ARITH_EN high for exactly 1 cycle.
- Sub wrap and mul: REQ1 A=3, B=5, FUN=01 gives RESULT=0xFFFFFFFE. Then A=0xFFFF, B=0xFFFF, FUN=10 gives RESULT=0xFFFE0001.
- Tie arbitration: both VALID held for 4 ops. Grants go REQ0, REQ1, REQ0, REQ1, and each response appears only on the matching RSPx_VALID.
- Division: REQ0 FUN=11, A=7, B=2. RSP0_VALID at T+1 with ERR=1, RESULT=0. ARITH_EN never asserted.
- Backpressure: hold RSP0_READY=0 for 10 cycles. RESULT stays stable, both REQx_READY stay 0, and REQ1 is accepted the cycle after the response handshake.
- Reset mid-op: assert RST low during WAIT. All outputs go to their reset values asynchronously, no response appears after release, and the next request completes normally.

Source files
------------

// File: rtl/arith_scheduler_pkg.sv
// Shared types and constants for the arithmetic-unit scheduler.
// State encoding, function codes and requester grant ids.
package arith_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_MUL = 2'b10;
  localparam logic [1:0] FUN_DIV = 2'b11;

  localparam logic GNT_REQ0 = 1'b0;
  localparam logic GNT_REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a last-grant register.
// Ties go to the requester opposite the previous winner.
module rr_arbiter2
  import arith_scheduler_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_grant;

  always_comb begin
    gnt_id = GNT_REQ0;
    unique case (1'b1)
      (req[0] && req[1]):  gnt_id = ~last_grant;
      (req[1] && !req[0]): gnt_id = GNT_REQ1;
      default:             gnt_id = GNT_REQ0;
    endcase
    gnt = 2'b00;
    if (en)
      gnt = req & (gnt_id ? 2'b10 : 2'b01);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      last_grant <= GNT_REQ1;
    else if (upd)
      last_grant <= gnt_id;
  end

endmodule

// File: rtl/arith_scheduler.sv
// Shares one add/sub/mul unit between two requesters.
// Issues one op at a time and returns the result to its owner.
module arith_scheduler
  import arith_scheduler_pkg::*;
#(
  parameter int A_width   = 16,
  parameter int B_width   = 16,
  parameter int OUT_width = A_width + B_width,
  parameter int ARITH_LAT = 1
)(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0_VALID,
  output logic                 REQ0_READY,
  input  logic [1:0]           REQ0_FUN,
  input  logic [A_width-1:0]   REQ0_A,
  input  logic [B_width-1:0]   REQ0_B,
  input  logic                 REQ1_VALID,
  output logic                 REQ1_READY,
  input  logic [1:0]           REQ1_FUN,
  input  logic [A_width-1:0]   REQ1_A,
  input  logic [B_width-1:0]   REQ1_B,
  output logic                 RSP0_VALID,
  input  logic                 RSP0_READY,
  output logic                 RSP1_VALID,
  input  logic                 RSP1_READY,
  output logic [OUT_width-1:0] RSP_RESULT,
  output logic                 RSP_CARRY,
  output logic                 RSP_ERR,
  output logic                 ARITH_EN,
  output logic [1:0]           ALU_FUN_ARITH,
  output logic [A_width-1:0]   A_IN_ARITH,
  output logic [B_width-1:0]   B_IN_ARITH,
  input  logic [OUT_width-1:0] ARITH_OUT
);

  localparam int CW = (ARITH_LAT > 1) ? $clog2(ARITH_LAT) : 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [1:0]         fun_q;
  logic [A_width-1:0] a_q;
  logic [B_width-1:0] b_q;
  logic               id_q;
  logic [1:0]         gnt;
  logic               gnt_id;
  logic               accept;
  logic [1:0]         sel_fun;
  logic [A_width-1:0] sel_a;
  logic [B_width-1:0] sel_b;

  rr_arbiter2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .en     (state == S_IDLE),
    .req    ({REQ1_VALID, REQ0_VALID}),
    .upd    (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign REQ0_READY = gnt[0];
  assign REQ1_READY = gnt[1];
  assign accept     = |gnt;
  assign sel_fun    = gnt_id ? REQ1_FUN : REQ0_FUN;
  assign sel_a      = gnt_id ? REQ1_A : REQ0_A;
  assign sel_b      = gnt_id ? REQ1_B : REQ0_B;

  assign ALU_FUN_ARITH = fun_q;
  assign A_IN_ARITH    = a_q;
  assign B_IN_ARITH    = b_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ARITH_EN   = 1'b0;
    RSP0_VALID = 1'b0;
    RSP1_VALID = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nxt = (sel_fun == FUN_DIV) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        ARITH_EN  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        RSP0_VALID = (id_q == GNT_REQ0);
        RSP1_VALID = (id_q == GNT_REQ1);
        if (id_q ? RSP1_READY : RSP0_READY)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Unit output is zeroed when EN drops, so capture only when cnt hits 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt        <= '0;
      fun_q      <= FUN_ADD;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= GNT_REQ0;
      RSP_RESULT <= '0;
      RSP_CARRY  <= 1'b0;
      RSP_ERR    <= 1'b0;
    end else begin
      if (accept) begin
        fun_q <= sel_fun;
        a_q   <= sel_a;
        b_q   <= sel_b;
        id_q  <= gnt_id;
        if (sel_fun == FUN_DIV) begin
          RSP_RESULT <= '0;
          RSP_CARRY  <= 1'b0;
          RSP_ERR    <= 1'b1;
        end
      end
      if (state == S_ISSUE)
        cnt <= CW'(ARITH_LAT - 1);
      if (state == S_WAIT) begin
        if (cnt == '0) begin
          RSP_RESULT <= ARITH_OUT;
          RSP_CARRY  <= ARITH_OUT[A_width];
          RSP_ERR    <= 1'b0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule
